// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE
    } state_e;

    localparam int LEN_WIDTH  = 16;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader (e.g. from a UART receiver).
interface imem_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid fires combinationally
// with the byte that completes a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    byte_en,
    input  logic [7:0]              byte_in,
    output logic                    word_valid,
    output logic [8*WORD_BYTES-1:0] word
);
    localparam int LANE_W = $clog2(WORD_BYTES);

    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [8*WORD_BYTES-1:0] shreg_q, shreg_d;

    // New bytes enter at the top, so after four shifts lane 0 sits in bits [7:0].
    always_comb begin
        lane_d     = lane_q;
        shreg_d    = shreg_q;
        word       = {byte_in, shreg_q[8*WORD_BYTES-1:8]};
        word_valid = byte_en && (lane_q == LANE_W'(WORD_BYTES - 1));
        if (clear) begin
            lane_d  = '0;
            shreg_d = '0;
        end else if (byte_en) begin
            lane_d  = lane_q + LANE_W'(1);
            shreg_d = word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a 16-bit word count then that many 32-bit words from a byte
// stream, writes them to instruction memory from address 0, and holds the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    imem_loader_if.slave          s,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  core_rst_n
);
    localparam logic [LEN_WIDTH:0] DEPTH = (LEN_WIDTH + 1)'(1) << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d, idx_next;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  in_load, accept, start_ok, word_valid;
    logic [31:0]           word;

    assign in_load  = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign accept   = s.s_valid && in_load;
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign idx_next = idx_q + LEN_WIDTH'(1);

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .byte_en   (accept && (state_q == DATA)),
        .byte_in   (s.s_data),
        .word_valid(word_valid),
        .word      (word)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d = LEN_LO;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                end else if (state_q == DONE) begin
                    // Delayed a cycle after entry so the final write lands first.
                    done_d = 1'b1;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = s.s_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[LEN_WIDTH-1:8] = s.s_data;
                    if ({s.s_data, len_q[7:0]} == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid) begin
                    idx_d = idx_next;
                    if ({1'b0, idx_q} < DEPTH) begin
                        we_d    = 1'b1;
                        waddr_d = idx_q[ADDR_WIDTH-1:0];
                        wdata_d = word;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (idx_next == len_q) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s.s_ready  = in_load;
    assign busy       = in_load;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign core_rst_n = done_q;
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory. It accepts a little-endian byte stream over a valid/ready interface, typically from a UART receiver. The stream is a 16-bit word count followed by that many 32-bit instruction words. Each assembled word is written to consecutive instruction-memory addresses starting at 0, and the CPU core is held in reset until the load completes.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; depth is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a byte; transfer occurs when s_valid && s_ready at a clk edge.
- we  out  1  instruction-memory write enable; one-cycle pulse per word.
- waddr  out  ADDR_WIDTH  word address for the write.
- wdata  out  32  instruction word for the write.
- busy  out  1  a load is in progress (states LEN_LO, LEN_HI, DATA).
- done  out  1  sticky flag: the last load completed; cleared by start.
- overflow  out  1  sticky flag: the word count exceeded the memory depth; cleared by start.
- core_rst_n  out  1  active-low reset to the core; equals done.

## Operation
- States:
  - IDLE is the reset state.
  - LEN_LO accepts the count low byte.
  - LEN_HI accepts the count high byte.
  - DATA accepts instruction bytes.
  - DONE follows a completed load.
- Transitions:
  - IDLE or DONE, on start: go to LEN_LO; clear done, overflow, the word index and the byte lane.
  - LEN_LO, on accept: go to LEN_HI.
  - LEN_HI, on accept: if {hi,lo} == 0, go to DONE; otherwise go to DATA.
  - DATA, when the 4th byte of the final word is accepted: go to DONE.
- s_ready is 1 in LEN_LO, LEN_HI and DATA, and 0 in IDLE and DONE.
- Byte order is little-endian:
  - Bytes land in lanes 0..3, so wdata = {b3,b2,b1,b0}.
  - The 2-bit lane counter wraps after lane 3.
- Word index is a 16-bit counter that increments once per completed word.
  - If index < 2^ADDR_WIDTH, the word is written with waddr = index[ADDR_WIDTH-1:0].
  - Otherwise we stays 0, overflow is set, and the stream is still fully consumed.
- A start pulse in LEN_LO, LEN_HI or DATA is ignored.
- Bytes presented while s_ready = 0 are not consumed, and nothing changes.

## Timing
- Reset values:
  - state = IDLE.
  - s_ready, we, busy, done, overflow, core_rst_n = 0.
  - waddr, wdata = 0.
- Reset asserted mid-load:
  - All outputs return to their reset values immediately (asynchronous).
  - A partially assembled word is discarded; nothing is written.
- Write latency:
  - we pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
  - waddr and wdata are valid in that same cycle and hold until the next write.
- Streaming:
  - s_ready stays 1 during the write cycle, so full throughput is 1 byte/cycle with no bubbles.
- Completion:
  - On entry to DONE, done and core_rst_n rise one cycle after the final we. The write therefore lands before the core leaves reset.
  - For count = 0, done rises the cycle after the LEN_HI accept.
- busy = 1 exactly while state is LEN_LO, LEN_HI or DATA.

## Structure
- Shared package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, DONE);
  - the constant LEN_WIDTH = 16;
  - the constant WORD_BYTES = 4.
- One natural sub-module, byte_packer:
  - holds the lane counter and the 32-bit shift/assembly register;
  - emits a one-cycle word_valid with the word;
  - has a clear input driven by start.
- The FSM, word counter, overflow and flags live in imem_loader.

## Test plan
- Reset behaviour: assert rst_n = 0 mid-cycle -> all outputs are 0 immediately, including s_ready = 0 and core_rst_n = 0, and start is accepted after release.
- Two-word load: start, then stream 02 00 93 00 10 00 13 01 20 00 back-to-back ->
  - we at waddr 0 with wdata 0x00100093;
  - we at waddr 1 with wdata 0x00200113;
  - done = core_rst_n = 1 one cycle after the second we.
- Backpressure and bubbles: the same stream with random s_valid gaps, plus start pulses injected while busy -> identical writes, no lost or duplicated bytes, and the start pulses are ignored.
- Zero-length load: stream 00 00 -> no we pulses; done = 1 the cycle after the second byte; s_ready = 0 afterwards.
- Overflow: with ADDR_WIDTH = 2 and count 5 (05 00 plus 20 bytes) ->
  - writes to waddr 0..3 only;
  - the 5th word is consumed without a we pulse;
  - overflow = 1 and done = 1.
- Reset mid-DATA: reset after 2 data bytes, then reload 01 00 EF BE AD DE -> a single we at waddr 0 with wdata 0xDEADBEEF.
